// File: rtl/regfile_bank_mp_pkg.sv
// Shared types and defaults for the multi-read-port register file bank.
// Latency: n/a (types only). Backpressure: n/a.
package regfile_pkg;

  typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;

  localparam int RF_DATAWIDTH = 32;
  localparam int RF_DATADEPTH = 32;

  function automatic int rf_addrwidth(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_bank_mp_if.sv
// Write port, per-port read addresses/data and ready flag of the register file bank.
// Latency: n/a (wiring only). Backpressure: none; master must honour ready before relying on data.
interface regfile_bank_mp_if
  import regfile_pkg::*;
#(
  parameter int DATAWIDTH = RF_DATAWIDTH,
  parameter int ADDRWIDTH = rf_addrwidth(RF_DATADEPTH),
  parameter int READPORTS = 2
);

  logic                                 writeEnable;
  logic [ADDRWIDTH-1:0]                 writeAddress;
  logic [DATAWIDTH-1:0]                 writeData;
  logic [READPORTS-1:0][ADDRWIDTH-1:0]  readAddress;
  logic [READPORTS-1:0][DATAWIDTH-1:0]  readData;
  logic                                 ready;

  modport master (
    output writeEnable, writeAddress, writeData, readAddress,
    input  readData, ready
  );

  modport slave (
    input  writeEnable, writeAddress, writeData, readAddress,
    output readData, ready
  );

endinterface

// File: rtl/regfile_bank_mp_read_port.sv
// One memory copy plus registered read output with zero-register and optional bypass (REGFILE_BYPASS_EN).
// Latency: 1 cycle address-to-data. Backpressure: none; output forced to 0 while en is low.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATAWIDTH = RF_DATAWIDTH,
  parameter int DATADEPTH = RF_DATADEPTH,
  parameter int ZEROREG   = 1,
  localparam int ADDRWIDTH = rf_addrwidth(DATADEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDRWIDTH-1:0] waddr,
  input  logic [DATAWIDTH-1:0] wdata,
  input  logic [ADDRWIDTH-1:0] raddr,
  output logic [DATAWIDTH-1:0] rdata
);

  logic [DATAWIDTH-1:0] mem [DATADEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // we already excludes dropped zero-register writes, so bypass never forwards them
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      rdata <= '0;
    end else if ((ZEROREG != 0) && (raddr == '0)) begin
      rdata <= '0;
`ifdef REGFILE_BYPASS_EN
    end else if (we && (waddr == raddr)) begin
      rdata <= wdata;
`endif
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/regfile_bank_mp.sv
// 1-write / READPORTS-read register file with hardware clear after reset; bypass via REGFILE_BYPASS_EN.
// Latency: 1 cycle reads, writes visible next read. Backpressure: none; ready low for DATADEPTH cycles after reset.
module regfile_bank_mp
  import regfile_pkg::*;
#(
  parameter int DATAWIDTH = RF_DATAWIDTH,
  parameter int DATADEPTH = RF_DATADEPTH,
  parameter int READPORTS = 2,
  parameter int ZEROREG   = 1,
  localparam int ADDRWIDTH = rf_addrwidth(DATADEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  regfile_bank_mp_if.slave bus
);

  if (DATADEPTH < 2 || (DATADEPTH & (DATADEPTH - 1)) != 0) begin : g_bad_depth
    $error("regfile_bank_mp: DATADEPTH must be a power of two >= 2");
  end
  if (READPORTS < 1) begin : g_bad_ports
    $error("regfile_bank_mp: READPORTS must be >= 1");
  end

  rf_state_t            state_q, state_d;
  logic [ADDRWIDTH-1:0] clear_addr_q, clear_addr_d;
  logic                 mem_we;
  logic [ADDRWIDTH-1:0] mem_waddr;
  logic [DATAWIDTH-1:0] mem_wdata;
  logic                 ext_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RF_CLEAR;
      clear_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
    end
  end

  assign ext_we = bus.writeEnable && !((ZEROREG != 0) && (bus.writeAddress == '0));

  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    mem_we       = 1'b0;
    mem_waddr    = bus.writeAddress;
    mem_wdata    = bus.writeData;
    case (state_q)
      RF_CLEAR: begin
        mem_we       = !reset;
        mem_waddr    = clear_addr_q;
        mem_wdata    = '0;
        clear_addr_d = clear_addr_q + 1'b1;
        if (clear_addr_q == ADDRWIDTH'(DATADEPTH - 1)) state_d = RF_READY;
      end
      RF_READY: begin
        mem_we = ext_we && !reset;
      end
      default: state_d = RF_CLEAR;
    endcase
  end

  assign bus.ready = (state_q == RF_READY);

  for (genvar p = 0; p < READPORTS; p++) begin : g_port
    logic [DATAWIDTH-1:0] rdata;

    regfile_read_port #(
      .DATAWIDTH (DATAWIDTH),
      .DATADEPTH (DATADEPTH),
      .ZEROREG   (ZEROREG)
    ) u_port (
      .clk   (clk),
      .reset (reset),
      .en    (bus.ready),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .raddr (bus.readAddress[p]),
      .rdata (rdata)
    );

    assign bus.readData[p] = rdata;
  end

endmodule

// File: tb/tb_regfile_bank_mp.sv
// Directed bench: instance a = 32x32, 2 ports, zero register; instance b = 64 deep, 4 ports, no zero register.
module tb_regfile_bank_mp;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  regfile_bank_mp_if #(.DATAWIDTH(32), .ADDRWIDTH(5), .READPORTS(2)) bus_a ();
  regfile_bank_mp_if #(.DATAWIDTH(32), .ADDRWIDTH(6), .READPORTS(4)) bus_b ();

  regfile_bank_mp #(.DATAWIDTH(32), .DATADEPTH(32), .READPORTS(2), .ZEROREG(1)) u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  regfile_bank_mp #(.DATAWIDTH(32), .DATADEPTH(64), .READPORTS(4), .ZEROREG(0)) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges until the chosen instance raises ready (0 = never within bound).
  task automatic wait_ready(input int which, output int n);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if ((which == 0 && bus_a.ready) || (which == 1 && bus_b.ready)) begin
        n = i;
        break;
      end
    end
  endtask

  logic [31:0] exp_bypass;
  logic [31:0] acc;
  int          na, nb, n;

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    bus_a.writeEnable = 1'b0; bus_a.writeAddress = '0; bus_a.writeData = '0; bus_a.readAddress = '0;
    bus_b.writeEnable = 1'b0; bus_b.writeAddress = '0; bus_b.writeData = '0; bus_b.readAddress = '0;

    // 1. reset state and clear timing
    tick();
    check_vec("rst_ready_a", {31'd0, bus_a.ready}, 32'd0);
    check_vec("rst_ready_b", {31'd0, bus_b.ready}, 32'd0);
    check_vec("rst_rd_a0", bus_a.readData[0], 32'd0);
    check_vec("rst_rd_a1", bus_a.readData[1], 32'd0);
    reset = 1'b0;
    na = 0; nb = 0; n = 0;
    while ((na == 0 || nb == 0) && n < 200) begin
      tick();
      n++;
      if (na == 0 && bus_a.ready) na = n;
      if (nb == 0 && bus_b.ready) nb = n;
      if (n == 10) check_vec("clear_rd_a0", bus_a.readData[0], 32'd0);
    end
    check_vec("ready_edge_a", 32'(na), 32'd32);
    check_vec("ready_edge_b", 32'(nb), 32'd64);

    acc = '0;
    for (int i = 0; i < 32; i++) begin
      bus_a.readAddress[0] = 5'(i);
      bus_a.readAddress[1] = 5'(31 - i);
      tick();
      acc = acc | bus_a.readData[0] | bus_a.readData[1];
    end
    check_vec("cleared_all_a", acc, 32'd0);

    // 2. write then read on both ports
    bus_a.writeEnable = 1'b1; bus_a.writeAddress = 5'd5; bus_a.writeData = 32'hDEADBEEF;
    tick();
    bus_a.writeEnable = 1'b0;
    bus_a.readAddress[0] = 5'd5; bus_a.readAddress[1] = 5'd5;
    tick();
    check_vec("r5_p0", bus_a.readData[0], 32'hDEADBEEF);
    check_vec("r5_p1", bus_a.readData[1], 32'hDEADBEEF);

    // 3. same-edge collision on r7
`ifdef REGFILE_BYPASS_EN
    exp_bypass = 32'h12345678;
`else
    exp_bypass = 32'h00000000;
`endif
    bus_a.writeEnable = 1'b1; bus_a.writeAddress = 5'd7; bus_a.writeData = 32'h12345678;
    bus_a.readAddress[0] = 5'd7; bus_a.readAddress[1] = 5'd5;
    tick();
    check_vec("r7_collide", bus_a.readData[0], exp_bypass);
    check_vec("r5_other_port", bus_a.readData[1], 32'hDEADBEEF);
    bus_a.writeEnable = 1'b0;
    tick();
    check_vec("r7_next", bus_a.readData[0], 32'h12345678);

    // 4. zero register (a) versus ordinary r0 (b)
    bus_a.writeEnable = 1'b1; bus_a.writeAddress = 5'd0; bus_a.writeData = 32'hFFFFFFFF;
    bus_a.readAddress[0] = 5'd0;
    tick();
    check_vec("r0_collide_zr", bus_a.readData[0], 32'd0);
    bus_a.writeEnable = 1'b0;
    tick();
    check_vec("r0_read_zr", bus_a.readData[0], 32'd0);
    bus_b.writeEnable = 1'b1; bus_b.writeAddress = 6'd0; bus_b.writeData = 32'hFFFFFFFF;
    tick();
    bus_b.writeEnable = 1'b0; bus_b.readAddress[0] = 6'd0;
    tick();
    check_vec("r0_read_nozr", bus_b.readData[0], 32'hFFFFFFFF);

    // 5. reset mid-clear, writes during clear ignored
    bus_a.writeEnable = 1'b1; bus_a.writeAddress = 5'd31; bus_a.writeData = 32'hA5A5A5A5;
    tick();
    bus_a.writeEnable = 1'b0; bus_a.readAddress[0] = 5'd31;
    tick();
    check_vec("r31_before_rst", bus_a.readData[0], 32'hA5A5A5A5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus_a.writeEnable = 1'b1; bus_a.writeAddress = 5'd3; bus_a.writeData = 32'h11111111;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 5) check_vec("clear_hold_r31", bus_a.readData[0], 32'd0);
    end
    reset = 1'b1;
    tick();
    check_vec("rerst_ready_a", {31'd0, bus_a.ready}, 32'd0);
    reset = 1'b0;
    bus_a.writeAddress = 5'd9; bus_a.writeData = 32'hCAFEF00D;
    wait_ready(0, n);
    check_vec("ready_edge_rerst", 32'(n), 32'd32);
    bus_a.writeEnable = 1'b0;
    bus_a.readAddress[0] = 5'd31; bus_a.readAddress[1] = 5'd9;
    tick();
    check_vec("r31_cleared", bus_a.readData[0], 32'd0);
    check_vec("r9_ignored", bus_a.readData[1], 32'd0);
    bus_a.readAddress[0] = 5'd3;
    tick();
    check_vec("r3_ignored", bus_a.readData[0], 32'd0);

    // 6. four ports, 64 deep
    n = 1;
    if (!bus_b.ready) wait_ready(1, n);
    check_vec("b_ready_after_rst", 32'(n != 0), 32'd1);
    for (int i = 0; i < 64; i++) begin
      bus_b.writeEnable = 1'b1; bus_b.writeAddress = 6'(i); bus_b.writeData = i * 32'h01010101;
      tick();
    end
    bus_b.writeEnable = 1'b0;
    bus_b.readAddress[0] = 6'd3;  bus_b.readAddress[1] = 6'd17;
    bus_b.readAddress[2] = 6'd63; bus_b.readAddress[3] = 6'd0;
    tick();
    check_vec("b_p0_r3",  bus_b.readData[0], 32'h03030303);
    check_vec("b_p1_r17", bus_b.readData[1], 32'h11111111);
    check_vec("b_p2_r63", bus_b.readData[2], 32'h3F3F3F3F);
    check_vec("b_p3_r0",  bus_b.readData[3], 32'h00000000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
